// File: rtl/div_result_queue.sv
// ----------------------------------------------------------------------------
// div_result_queue
//  Result queue placed after the combinational restoring divider. Each
//  accepted divider result is stored with its divide-by-zero flag in a
//  DEPTH-entry FIFO. The FIFO is presented to the consumer over valid/ready.
//  A divide-by-zero result is replaced by {quot = all ones, rem = dividend}.
//
//  Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     divider result valid this cycle
//   in_ready     queue can accept (count != DEPTH)
//   in_dividend  dividend presented to the divider
//   in_divisor   divisor presented to the divider
//   in_quot      divider quotient
//   in_rem       divider remainder
//   out_valid    head entry valid (count != 0)
//   out_ready    consumer accepts the head this cycle
//   out_quot     head quotient
//   out_rem      head remainder
//   out_dbz      head entry was a divide-by-zero
//   count        number of entries held, 0..DEPTH
//   dbz_cnt      saturating count of accepted divide-by-zero entries
// ----------------------------------------------------------------------------
module div_result_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [WIDTH-1:0] in_quot,
    input  logic [WIDTH-1:0] in_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_dbz,
    output logic [AW:0]      count,
    output logic [7:0]       dbz_cnt
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Packs one queue entry as {quot, rem, dbz}. A zero divisor makes the
    // divider's quotient/remainder meaningless, so they are replaced.
    function automatic logic [2*WIDTH:0] make_entry(
        input logic [WIDTH-1:0] dividend,
        input logic [WIDTH-1:0] divisor,
        input logic [WIDTH-1:0] quot,
        input logic [WIDTH-1:0] rem
    );
        if (divisor == {WIDTH{1'b0}}) begin
            make_entry = {{WIDTH{1'b1}}, dividend, 1'b1};
        end else begin
            make_entry = {quot, rem, 1'b0};
        end
    endfunction

    logic [WIDTH-1:0] quot_mem_r [DEPTH];
    logic [WIDTH-1:0] rem_mem_r  [DEPTH];
    logic             dbz_mem_r  [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [7:0]       dbz_cnt_r;

    logic             push_s;
    logic             pop_s;
    logic [2*WIDTH:0] entry_s;
    logic [AW:0]      count_nxt_s;

    // Handshake flags decode straight from the occupancy register, so a pop
    // never opens in_ready in the same cycle.
    assign in_ready  = (count_r != FULL_CNT);
    assign out_valid = (count_r != {(AW+1){1'b0}});
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    assign out_quot = quot_mem_r[rd_ptr_r];
    assign out_rem  = rem_mem_r[rd_ptr_r];
    assign out_dbz  = dbz_mem_r[rd_ptr_r];
    assign count    = count_r;
    assign dbz_cnt  = dbz_cnt_r;

    // Entry formation for the incoming divider result.
    always_comb begin
        entry_s = make_entry(in_dividend, in_divisor, in_quot, in_rem);
    end

    // Next occupancy: push+pop together leaves the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Entry storage; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                quot_mem_r[i] <= {WIDTH{1'b0}};
                rem_mem_r[i]  <= {WIDTH{1'b0}};
                dbz_mem_r[i]  <= 1'b0;
            end
        end else if (push_s) begin
            quot_mem_r[wr_ptr_r] <= entry_s[2*WIDTH:WIDTH+1];
            rem_mem_r[wr_ptr_r]  <= entry_s[WIDTH:1];
            dbz_mem_r[wr_ptr_r]  <= entry_s[0];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {(AW+1){1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    // Divide-by-zero counter, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz_cnt_r <= 8'd0;
        end else if (push_s && entry_s[0] && (dbz_cnt_r != 8'hFF)) begin
            dbz_cnt_r <= dbz_cnt_r + 8'd1;
        end
    end

endmodule

// File: tb/tb_div_result_queue.sv
module tb_div_result_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_dividend;
    logic [7:0] in_divisor;
    logic [7:0] in_quot;
    logic [7:0] in_rem;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_quot;
    logic [7:0] out_rem;
    logic       out_dbz;
    logic [2:0] count;
    logic [7:0] dbz_cnt;

    always #5 clk = ~clk;

    div_result_queue #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .in_quot(in_quot), .in_rem(in_rem),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quot(out_quot), .out_rem(out_rem), .out_dbz(out_dbz),
        .count(count), .dbz_cnt(dbz_cnt)
    );

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       d;
    } ent_t;

    typedef struct {
        logic       iv;
        logic [7:0] a;
        logic [7:0] b;
        logic       ordy;
        int         exp_count;
        logic       exp_in_ready;
        logic       exp_out_valid;
        logic [7:0] exp_quot;
    } vec_t;

    ent_t sb[$];
    int   mcount = 0;
    int   mdbz   = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Drives one cycle of stimulus, updates the scoreboard model, and checks
    // the DUT state just after the clock edge.
    task automatic drive(input logic iv, input logic [7:0] a, input logic [7:0] b,
                         input logic ordy);
        ent_t e;
        logic push_m;
        logic pop_m;
        in_valid    = iv;
        in_dividend = a;
        in_divisor  = b;
        out_ready   = ordy;
        if (b != 8'd0) begin
            in_quot = a / b;
            in_rem  = a % b;
            e.q = a / b;
            e.r = a % b;
            e.d = 1'b0;
        end else begin
            in_quot = 8'h5A;
            in_rem  = 8'hA5;
            e.q = 8'hFF;
            e.r = a;
            e.d = 1'b1;
        end
        push_m = iv && (mcount != 4);
        pop_m  = ordy && (mcount != 0);
        @(posedge clk);
        #1;
        if (pop_m) void'(sb.pop_front());
        if (push_m) begin
            sb.push_back(e);
            if (e.d && mdbz != 255) mdbz++;
        end
        mcount = mcount + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
        chk("count", 32'(count), 32'(mcount));
        chk("in_ready", 32'(in_ready), 32'(mcount != 4));
        chk("out_valid", 32'(out_valid), 32'(mcount != 0));
        chk("dbz_cnt", 32'(dbz_cnt), 32'(mdbz));
        if (mcount != 0) begin
            chk("head_quot", 32'(out_quot), 32'(sb[0].q));
            chk("head_rem", 32'(out_rem), 32'(sb[0].r));
            chk("head_dbz", 32'(out_dbz), 32'(sb[0].d));
        end
    endtask

    vec_t fill_tbl[10];

    initial begin
        // Fill / full / drain sequence with hand-derived expectations (B=3).
        fill_tbl[0] = '{1'b1, 8'd10, 8'd3, 1'b0, 1, 1'b1, 1'b1, 8'd3};
        fill_tbl[1] = '{1'b1, 8'd20, 8'd3, 1'b0, 2, 1'b1, 1'b1, 8'd3};
        fill_tbl[2] = '{1'b1, 8'd30, 8'd3, 1'b0, 3, 1'b1, 1'b1, 8'd3};
        fill_tbl[3] = '{1'b1, 8'd40, 8'd3, 1'b0, 4, 1'b0, 1'b1, 8'd3};
        fill_tbl[4] = '{1'b1, 8'd50, 8'd3, 1'b0, 4, 1'b0, 1'b1, 8'd3};
        fill_tbl[5] = '{1'b1, 8'd50, 8'd3, 1'b1, 3, 1'b1, 1'b1, 8'd6};
        fill_tbl[6] = '{1'b1, 8'd50, 8'd3, 1'b1, 3, 1'b1, 1'b1, 8'd10};
        fill_tbl[7] = '{1'b0, 8'd0,  8'd3, 1'b1, 2, 1'b1, 1'b1, 8'd13};
        fill_tbl[8] = '{1'b0, 8'd0,  8'd3, 1'b1, 1, 1'b1, 1'b1, 8'd16};
        fill_tbl[9] = '{1'b0, 8'd0,  8'd3, 1'b1, 0, 1'b1, 1'b0, 8'd0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_dividend = 8'd0;
        in_divisor = 8'd1;
        in_quot = 8'd0;
        in_rem = 8'd0;
        out_ready = 1'b0;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_quot", 32'(out_quot), 32'd0);
        chk("rst_out_rem", 32'(out_rem), 32'd0);
        chk("rst_out_dbz", 32'(out_dbz), 32'd0);
        chk("rst_dbz_cnt", 32'(dbz_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: single push, then pop
        drive(1'b1, 8'd200, 8'd7, 1'b0);
        chk("t2_quot", 32'(out_quot), 32'd28);
        chk("t2_rem", 32'(out_rem), 32'd4);
        chk("t2_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 8'd0, 8'd1, 1'b1);
        chk("t2_count", 32'(count), 32'd0);

        // 3: table-driven fill, full, drain
        for (int i = 0; i < 10; i++) begin
            drive(fill_tbl[i].iv, fill_tbl[i].a, fill_tbl[i].b, fill_tbl[i].ordy);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(fill_tbl[i].exp_count));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(fill_tbl[i].exp_in_ready));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(fill_tbl[i].exp_out_valid));
            if (fill_tbl[i].exp_out_valid)
                chk($sformatf("tbl%0d_quot", i), 32'(out_quot), 32'(fill_tbl[i].exp_quot));
        end

        // 4: divide by zero
        drive(1'b1, 8'd55, 8'd0, 1'b0);
        chk("t4_quot", 32'(out_quot), 32'hFF);
        chk("t4_rem", 32'(out_rem), 32'd55);
        chk("t4_dbz", 32'(out_dbz), 32'd1);
        chk("t4_dbz_cnt", 32'(dbz_cnt), 32'd1);
        drive(1'b0, 8'd0, 8'd1, 1'b1);

        // 5: streaming push+pop, count steady at 1, pointers wrap
        drive(1'b1, 8'd0, 8'd3, 1'b1);
        for (int i = 1; i < 20; i++) begin
            drive(1'b1, 8'(i), 8'd3, 1'b1);
            chk("t5_count", 32'(count), 32'd1);
            chk("t5_quot", 32'(out_quot), 32'(i / 3));
        end
        drive(1'b0, 8'd0, 8'd3, 1'b1);

        // dbz_cnt saturation: stream divide-by-zero results
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 8'(i), 8'd0, 1'b1);
        end
        chk("sat_dbz_cnt", 32'(dbz_cnt), 32'd255);
        drive(1'b0, 8'd0, 8'd1, 1'b1);

        // 6: reset mid-operation
        drive(1'b1, 8'd9, 8'd2, 1'b0);
        drive(1'b1, 8'd8, 8'd2, 1'b0);
        drive(1'b1, 8'd7, 8'd2, 1'b0);
        chk("t6_pre_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        mcount = 0;
        mdbz = 0;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_dbz_cnt", 32'(dbz_cnt), 32'd0);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'd77, 8'd5, 1'b0);
        chk("t6_head_quot", 32'(out_quot), 32'd15);
        chk("t6_head_rem", 32'(out_rem), 32'd2);
        chk("t6_head_count", 32'(count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
